// File: rtl/game_selector_mux.sv
// rtl/game_selector_mux.sv - active-game selector with splash, display mux and button routing
module game_selector_mux #(
    parameter int NUM_GAMES     = 4,
    parameter int NUM_BTNS      = 2,
    parameter int VAL_W         = 4,
    parameter int SEL_W         = 2,
    parameter int SPLASH_CYCLES = 1000,
    parameter int BLANK_CODE    = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          next_pulse,
    input  logic                          prev_pulse,
    input  logic [NUM_BTNS-1:0]           btn_pulse,
    input  logic [NUM_GAMES-1:0]          game_enable,
    input  logic [NUM_GAMES*VAL_W-1:0]    game_values,
    output logic [NUM_GAMES*NUM_BTNS-1:0] game_btn,
    output logic [SEL_W-1:0]              sel,
    output logic                          splash_active,
    output logic [VAL_W-1:0]              display_value
);

    localparam int CNT_W = (SPLASH_CYCLES > 0) ? $clog2(SPLASH_CYCLES + 1) : 1;
    localparam int SW1   = SEL_W + 1;
    localparam logic [CNT_W-1:0] SPLASH_LOAD = CNT_W'(SPLASH_CYCLES);
    localparam logic [SEL_W:0]   NG_WIDE     = SW1'(NUM_GAMES);

    generate
        if (NUM_GAMES < 2 || NUM_GAMES > 16 || NUM_GAMES > (1 << SEL_W) || SEL_W > VAL_W ||
            NUM_BTNS < 1 || NUM_BTNS > 7 || SPLASH_CYCLES < 0) begin : g_bad_params
            $fatal(1, "game_selector_mux: illegal parameter combination");
        end
    endgenerate

    logic [NUM_GAMES-1:0] en_rot;
    logic [SEL_W-1:0]     next_off;
    logic [SEL_W-1:0]     prev_off;
    logic [SEL_W:0]       target_sum;
    logic [SEL_W-1:0]     target;
    logic                 other_found;
    logic                 do_next;
    logic                 do_prev;
    logic                 do_switch;
    logic                 cur_en;
    logic [VAL_W-1:0]     cur_val;
    logic [CNT_W-1:0]     splash_cnt;

    // en_rot[j] is the enable of slot (sel + j) mod NUM_GAMES, so wrap happens at NUM_GAMES.
    assign en_rot      = NUM_GAMES'({game_enable, game_enable} >> sel);
    assign cur_en      = en_rot[0];
    assign other_found = |en_rot[NUM_GAMES-1:1];

    // Next is the smallest enabled forward offset; prev is the largest (i.e. nearest backward).
    always_comb begin
        next_off = '0;
        prev_off = '0;
        for (int j = NUM_GAMES - 1; j >= 1; j--) begin
            if (en_rot[j]) next_off = SEL_W'(j);
        end
        for (int j = 1; j < NUM_GAMES; j++) begin
            if (en_rot[j]) prev_off = SEL_W'(j);
        end
    end

    assign do_next   = next_pulse & ~prev_pulse;
    assign do_prev   = prev_pulse & ~next_pulse;
    assign do_switch = (do_next | do_prev) & other_found;

    always_comb begin
        target_sum = {1'b0, sel} + {1'b0, (do_next ? next_off : prev_off)};
        if (target_sum >= NG_WIDE) target_sum = target_sum - NG_WIDE;
    end
    assign target = target_sum[SEL_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= '0;
            splash_cnt <= '0;
        end else if (do_switch) begin
            sel        <= target;
            splash_cnt <= SPLASH_LOAD;
        end else if (splash_cnt != '0) begin
            splash_cnt <= splash_cnt - CNT_W'(1);
        end
    end

    assign splash_active = (splash_cnt != '0);

    // Buttons go to the currently registered sel, so a pulse coinciding with a switch hits the old slot.
    always_comb begin
        cur_val  = '0;
        game_btn = '0;
        for (int g = 0; g < NUM_GAMES; g++) begin
            if (sel == SEL_W'(g)) begin
                cur_val = game_values[g*VAL_W +: VAL_W];
                if (cur_en && !splash_active) game_btn[g*NUM_BTNS +: NUM_BTNS] = btn_pulse;
            end
        end
    end

    assign display_value = splash_active ? VAL_W'(sel) :
                           (cur_en ? cur_val : VAL_W'(BLANK_CODE));

endmodule

// File: tb/tb_game_selector_mux.sv
// tb/tb_game_selector_mux.sv - directed and random checks of game_selector_mux against a reference model
module tb_game_selector_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next_pulse = 1'b0;
    logic        prev_pulse = 1'b0;
    logic [1:0]  btn_pulse = 2'b00;
    logic [3:0]  en4 = 4'b1111;
    logic [2:0]  en3 = 3'b111;
    logic [15:0] vals = 16'h9A5B;

    logic [7:0]  gb4;
    logic [1:0]  sel4;
    logic        sp4;
    logic [3:0]  dv4;
    logic [5:0]  gb3;
    logic [1:0]  sel3;
    logic        sp3;
    logic [3:0]  dv3;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int m_sel [2];
    int m_cnt [2];
    int hi;

    always #5 clk = ~clk;

    game_selector_mux #(
        .NUM_GAMES(4), .NUM_BTNS(2), .VAL_W(4), .SEL_W(2), .SPLASH_CYCLES(4), .BLANK_CODE(12)
    ) dut4 (
        .clk(clk), .reset(reset), .next_pulse(next_pulse), .prev_pulse(prev_pulse),
        .btn_pulse(btn_pulse), .game_enable(en4), .game_values(vals),
        .game_btn(gb4), .sel(sel4), .splash_active(sp4), .display_value(dv4)
    );

    game_selector_mux #(
        .NUM_GAMES(3), .NUM_BTNS(2), .VAL_W(4), .SEL_W(2), .SPLASH_CYCLES(2), .BLANK_CODE(12)
    ) dut3 (
        .clk(clk), .reset(reset), .next_pulse(next_pulse), .prev_pulse(prev_pulse),
        .btn_pulse(btn_pulse), .game_enable(en3), .game_values(vals[11:0]),
        .game_btn(gb3), .sel(sel3), .splash_active(sp3), .display_value(dv3)
    );

    function automatic int num_games(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int splash_len(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int enables(int d);
        return (d == 0) ? int'(en4) : int'(en3);
    endfunction

    // First enabled slot walking from s in direction dir, excluding s; -1 if none.
    function automatic int find_slot(int s, int dir, int en, int n);
        for (int k = 1; k < n; k++) begin
            int c;
            c = ((s + dir * k) % n + n) % n;
            if (((en >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int en, e_dv, e_gb, o_gb, o_sel, o_sp, o_dv;
            bit spl, cur;
            en   = enables(d);
            spl  = (m_cnt[d] > 0);
            cur  = (((en >> m_sel[d]) & 1) == 1);
            if (spl) e_dv = m_sel[d];
            else if (cur) e_dv = (int'(vals) >> (4 * m_sel[d])) & 15;
            else e_dv = 12;
            e_gb  = (!spl && cur) ? (int'(btn_pulse) << (2 * m_sel[d])) : 0;
            o_gb  = (d == 0) ? int'(gb4) : int'(gb3);
            o_sel = (d == 0) ? int'(sel4) : int'(sel3);
            o_sp  = (d == 0) ? int'(sp4) : int'(sp3);
            o_dv  = (d == 0) ? int'(dv4) : int'(dv3);
            chk($sformatf("d%0d_sel", d), o_sel, m_sel[d]);
            chk($sformatf("d%0d_splash", d), o_sp, int'(spl));
            chk($sformatf("d%0d_display", d), o_dv, e_dv);
            chk($sformatf("d%0d_game_btn", d), o_gb, e_gb);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sel[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    task automatic drive(input logic n, input logic p, input logic [1:0] b);
        @(negedge clk);
        next_pulse = n;
        prev_pulse = p;
        btn_pulse  = b;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else begin
            for (int d = 0; d < 2; d++) begin
                int t;
                t = -1;
                if (next_pulse != prev_pulse)
                    t = find_slot(m_sel[d], next_pulse ? 1 : -1, enables(d), num_games(d));
                if (t >= 0) begin
                    m_sel[d] = t;
                    m_cnt[d] = splash_len(d);
                end else if (m_cnt[d] > 0) begin
                    m_cnt[d]--;
                end
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b0, 1'b0, 2'b00);
            tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        next_pulse = 1'b0;
        prev_pulse = 1'b0;
        btn_pulse  = 2'b00;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state, slot 0 disabled then enabled
        en4 = 4'b1110;
        do_reset();
        chk("reset_sel", int'(sel4), 0);
        chk("reset_splash", int'(sp4), 0);
        chk("reset_blank", int'(dv4), 12);
        en4 = 4'b1111;
        drive(1'b0, 1'b0, 2'b00);
        chk("reset_slot0", int'(dv4), 11);
        tick();

        // Forward wrap with splash display
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 2'b00);
            tick();
            chk("wrap_sel", int'(sel4), (k + 1) % 4);
            chk("wrap_splash_disp", int'(dv4), (k + 1) % 4);
            idle(5);
        end

        // Reset two cycles into a splash
        drive(1'b1, 1'b0, 2'b00);
        tick();
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_sel", int'(sel4), 0);
        chk("midreset_splash", int'(sp4), 0);
        chk("midreset_disp", int'(dv4), 11);
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 2'b00);
        tick();
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 2'b00);
            hi += int'(sp4);
            tick();
        end
        chk("splash_len_after_reset", hi, 4);

        // Skip and prev on the 3-slot instance
        do_reset();
        en3 = 3'b101;
        drive(1'b1, 1'b0, 2'b00); tick();
        chk("skip_next", int'(sel3), 2);
        idle(3);
        drive(1'b0, 1'b1, 2'b00); tick();
        chk("skip_prev", int'(sel3), 0);
        idle(3);
        drive(1'b1, 1'b0, 2'b00); tick();
        chk("skip_next2", int'(sel3), 2);
        idle(3);
        drive(1'b1, 1'b0, 2'b00); tick();
        chk("wrap_at_2", int'(sel3), 0);
        idle(3);

        // Button routing, splash suppression, simultaneous events
        do_reset();
        en4 = 4'b1111;
        drive(1'b1, 1'b0, 2'b00); tick();
        idle(5);
        drive(1'b0, 1'b0, 2'b01);
        chk("route_slot1", int'(gb4), 8'b0000_0100);
        tick();
        drive(1'b1, 1'b0, 2'b00); tick();
        drive(1'b0, 1'b0, 2'b01);
        chk("route_in_splash", int'(gb4), 0);
        tick();
        idle(5);
        drive(1'b1, 1'b1, 2'b00); tick();
        chk("both_sel", int'(sel4), 2);
        chk("both_splash", int'(sp4), 0);
        drive(1'b1, 1'b0, 2'b10);
        chk("btn_with_next", int'(gb4), 8'b0010_0000);
        tick();
        chk("btn_with_next_sel", int'(sel4), 3);
        idle(5);

        // Disabled current slot, re-enable, single enabled slot
        en4 = 4'b0111;
        drive(1'b0, 1'b0, 2'b01);
        chk("disabled_disp", int'(dv4), 12);
        chk("disabled_btn", int'(gb4), 0);
        tick();
        en4 = 4'b1111;
        drive(1'b0, 1'b0, 2'b00);
        chk("reenabled_disp", int'(dv4), 9);
        chk("reenabled_splash", int'(sp4), 0);
        tick();
        en4 = 4'b1000;
        drive(1'b1, 1'b0, 2'b00); tick();
        chk("only_one_next", int'(sel4), 3);
        chk("only_one_splash", int'(sp4), 0);
        drive(1'b0, 1'b1, 2'b00); tick();
        chk("only_one_prev", int'(sel4), 3);

        // Random traffic
        en4 = 4'b1111;
        en3 = 3'b111;
        for (int i = 0; i < 400; i++) begin
            logic n, p;
            if ($urandom_range(0, 7) == 0) en4 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) en3 = 3'($urandom);
            vals = 16'($urandom);
            n = ($urandom_range(0, 4) == 0);
            p = ($urandom_range(0, 4) == 0);
            drive(n, p, 2'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
